// File: rtl/uart_tx_arbiter.sv
// Two-source round-robin arbiter in front of a single 8N1 UART transmitter.
// A byte is taken on a valid/ready handshake in IDLE and sent LSB first.
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant_id,
    output logic       frame_done
);
    // state | meaning
    // IDLE  | line high, waiting for a handshake
    // START | start bit (low)
    // DATA  | data bits, LSB first, indexed by bit_idx
    // STOP  | stop bit (high), frame_done on its last cycle
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CLKS_PER_BIT - 2);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [7:0]       shift, shift_d;
    logic             tx_d, busy_d, grant_d, frame_done_d;
    logic             last_grant, last_grant_d;
    logic             winner, xfer, end_bit;

    // Ties go to the requester that was not served last.
    assign winner     = req1_valid && (!req0_valid || !last_grant);
    assign req0_ready = rst_n && (state == IDLE) && req0_valid && !winner;
    assign req1_ready = rst_n && (state == IDLE) && req1_valid && winner;
    assign xfer       = req0_ready || req1_ready;
    assign end_bit    = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
            frame_done <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bit_idx    <= bit_idx_d;
            shift      <= shift_d;
            tx         <= tx_d;
            busy       <= busy_d;
            grant_id   <= grant_d;
            frame_done <= frame_done_d;
            last_grant <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt + 1'b1;
        bit_idx_d    = bit_idx;
        shift_d      = shift;
        tx_d         = tx;
        busy_d       = busy;
        grant_d      = grant_id;
        frame_done_d = 1'b0;
        last_grant_d = last_grant;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (xfer) begin
                    shift_d      = winner ? req1_data : req0_data;
                    grant_d      = winner;
                    last_grant_d = winner;
                    busy_d       = 1'b1;
                    tx_d         = 1'b0;
                    bit_idx_d    = '0;
                    state_d      = START;
                end
            end
            START: begin
                if (end_bit) begin
                    cnt_d   = '0;
                    tx_d    = shift[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (end_bit) begin
                    cnt_d = '0;
                    if (bit_idx == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        tx_d      = shift[1];
                        shift_d   = {1'b0, shift[7:1]};
                    end
                end
            end
            STOP: begin
                // Registered pulse: set one cycle early so it lands on the last stop cycle.
                if (cnt == CNT_PRE) frame_done_d = 1'b1;
                if (end_bit) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with CLKS_PER_BIT = 4.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_uart_tx_arbiter;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req0_data = '0, req1_data = '0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready, tx, busy, grant_id, frame_done;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .tx(tx), .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_fdone", frame_done, 0);
        chk("rst_ready", {req1_ready, req0_ready}, 0);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for a ready; reports which requester and how many cycles it took.
    task automatic wait_ready(output logic id, output int waited);
        waited = 0;
        #1;
        while (!(req0_ready || req1_ready) && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("ready_timeout", (req0_ready || req1_ready), 1);
        chk("ready_onehot", (req0_ready && req1_ready), 0);
        id = req1_ready;
    endtask

    // Called in the handshake cycle (cycle 0); checks cycles 1..last of the frame.
    task automatic check_frame(input logic id, input logic [7:0] b, input logic [1:0] drop,
                               input int last);
        logic exp_tx;
        @(posedge clk);
        #1;
        if (drop[0]) req0_valid = 1'b0;
        if (drop[1]) req1_valid = 1'b0;
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            if (n <= C)            exp_tx = 1'b0;
            else if (n <= 9 * C)   exp_tx = b[(n - C - 1) / C];
            else                   exp_tx = 1'b1;
            chk("frame_tx", tx, exp_tx);
            chk("frame_busy", busy, (n <= 10 * C));
            chk("frame_fdone", frame_done, (n == 10 * C));
            chk("frame_grant", grant_id, id);
            if (n <= 10 * C) chk("frame_ready_low", {req1_ready, req0_ready}, 0);
        end
    endtask

    logic id;
    int   waited;

    initial begin
        // 1: single byte from req0
        apply_reset();
        req0_data  = 8'h55;
        req0_valid = 1'b1;
        wait_ready(id, waited);
        chk("s1_id", id, 0);
        check_frame(1'b0, 8'h55, 2'b01, 41);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s1_idle_tx", tx, 1);
            chk("s1_ready0", req0_ready, 0);
        end

        // 2: tie after reset, req0 first then req1 right behind it
        apply_reset();
        req0_data  = 8'hA3;
        req1_data  = 8'h3C;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_ready(id, waited);
        chk("s2_first_id", id, 0);
        chk("s2_first_wait", waited, 0);
        check_frame(1'b0, 8'hA3, 2'b01, 41);
        wait_ready(id, waited);
        chk("s2_second_id", id, 1);
        chk("s2_gap", waited, 0);
        check_frame(1'b1, 8'h3C, 2'b10, 41);

        // 3: both held for four frames, grants alternate
        apply_reset();
        req0_data  = 8'h81;
        req1_data  = 8'h7E;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_ready(id, waited);
            chk("s3_id", id, f % 2);
            chk("s3_gap", waited, 0);
            check_frame(logic'(f % 2), (f % 2) ? 8'h7E : 8'h81, (f == 3) ? 2'b11 : 2'b00, 41);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // 4: reset during data bit 3 of 0xFF, then held req1 goes right away
        apply_reset();
        req0_data  = 8'hFF;
        req0_valid = 1'b1;
        wait_ready(id, waited);
        check_frame(1'b0, 8'hFF, 2'b01, 18);
        rst_n      = 1'b0;
        req1_data  = 8'h96;
        req1_valid = 1'b1;
        #1;
        chk("s4_abort_tx", tx, 1);
        chk("s4_abort_busy", busy, 0);
        chk("s4_abort_grant", grant_id, 0);
        @(negedge clk);
        chk("s4_rst_ready1", req1_ready, 0);
        rst_n = 1'b1;
        wait_ready(id, waited);
        chk("s4_id", id, 1);
        chk("s4_wait", waited, 0);
        check_frame(1'b1, 8'h96, 2'b10, 41);

        // 5: short req1 pulse during a req0 frame is dropped
        apply_reset();
        req0_data  = 8'h5A;
        req1_data  = 8'hC3;
        req0_valid = 1'b1;
        wait_ready(id, waited);
        chk("s5_id", id, 0);
        fork
            check_frame(1'b0, 8'h5A, 2'b01, 41);
            begin
                repeat (10) @(posedge clk);
                #1 req1_valid = 1'b1;
                repeat (3) @(posedge clk);
                #1 req1_valid = 1'b0;
            end
        join
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("s5_idle_tx", tx, 1);
            chk("s5_idle_busy", busy, 0);
            chk("s5_ready1", req1_ready, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
